// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter, its two requesters (CPU, host) and the memory.
// Handshake: a requester raises req with wr/addr/wdata stable and holds them until it sees a one-cycle ack.
interface mem_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 8
);
    logic          cpu_req;
    logic          cpu_wr;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;

    logic          hst_req;
    logic          hst_wr;
    logic [AW-1:0] hst_addr;
    logic [DW-1:0] hst_wdata;
    logic          hst_ack;
    logic [DW-1:0] hst_rdata;

    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          last_gnt;
    logic          busy;

    modport slave (
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  hst_req, hst_wr, hst_addr, hst_wdata,
        output hst_ack, hst_rdata,
        output mem_en, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata,
        output last_gnt, busy
    );

    modport master (
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output hst_req, hst_wr, hst_addr, hst_wdata,
        input  hst_ack, hst_rdata,
        input  mem_en, mem_wr, mem_addr, mem_wdata,
        output mem_rdata,
        input  last_gnt, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory between the CPU (port 0) and host (port 1).
// One transaction at a time: IDLE -> ACCESS (MEM_LAT cycles) -> RESP (ack) -> IDLE.
module mem_arbiter #(
    parameter int AW      = 5,
    parameter int DW      = 8,
    parameter int MEM_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus,
    output logic [1:0]   state_dbg
);

    generate
        if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
            $error("mem_arbiter: MEM_LAT must be in 1..4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [2:0]    lat_cnt;
    logic          gnt_port;
    logic          gnt_wr;
    logic          last_gnt_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] hst_rdata_q;
    logic          grant;
    logic          grant_port;
    logic          lat_done;

    // Tie goes to the port that did not win last time.
    always_comb begin
        grant      = 1'b0;
        grant_port = 1'b0;
        if (bus.cpu_req && bus.hst_req) begin
            grant      = 1'b1;
            grant_port = ~last_gnt_q;
        end else if (bus.cpu_req) begin
            grant      = 1'b1;
            grant_port = 1'b0;
        end else if (bus.hst_req) begin
            grant      = 1'b1;
            grant_port = 1'b1;
        end
    end

    assign lat_done = (lat_cnt == 3'(MEM_LAT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = ACCESS;
            ACCESS:  if (lat_done) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_cnt     <= 3'd0;
            gnt_port    <= 1'b0;
            gnt_wr      <= 1'b0;
            last_gnt_q  <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            hst_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        gnt_port   <= grant_port;
                        last_gnt_q <= grant_port;
                        gnt_wr     <= grant_port ? bus.hst_wr    : bus.cpu_wr;
                        addr_q     <= grant_port ? bus.hst_addr  : bus.cpu_addr;
                        wdata_q    <= grant_port ? bus.hst_wdata : bus.cpu_wdata;
                        lat_cnt    <= 3'd1;
                    end
                end
                ACCESS: begin
                    if (lat_done) begin
                        lat_cnt <= 3'd0;
                        // Read data lands in the port's rdata register on RESP entry.
                        if (!gnt_wr) begin
                            if (gnt_port) hst_rdata_q <= bus.mem_rdata;
                            else          cpu_rdata_q <= bus.mem_rdata;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_en    = (state_q == ACCESS) && (lat_cnt == 3'd1);
    assign bus.mem_wr    = (state_q == ACCESS) && gnt_wr;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.cpu_ack   = (state_q == RESP) && !gnt_port;
    assign bus.hst_ack   = (state_q == RESP) && gnt_port;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.hst_rdata = hst_rdata_q;
    assign bus.last_gnt  = last_gnt_q;
    assign bus.busy      = (state_q != IDLE);
    assign state_dbg     = state_q;

endmodule
